slave_if: RTL and testbench
===========================

// Module: slave_if
// PURPOSE
//   Slave-side port of the crossbar: accepts a granted request from the crossbar and replays it
//   to one slave. Returns ack/rdata to the crossbar. Registered Moore FSM; one transaction in flight.
//   Converts global to local address and times out a silent slave with an error response.
// PARAMETERS
//   BASE_ADDR       32'h0000_0000  global base of this slave; addr_to_slave = captured addr - BASE_ADDR (mod 2^32)
//   TIMEOUT_CYCLES  16             max cycles in REQ without ack_from_slave; 0 disables the timeout
//   ERR_RDATA       32'hDEAD_BEEF  rdata returned on a timed-out read
// PORTS
//   clk                  in   1   clock, all state on rising edge
//   rst                  in   1   synchronous reset, active high
//   req_from_crossbar    in   1   request; crossbar holds high until it sees ack_to_crossbar
//   addr_from_crossbar   in   32  global address
//   wdata_from_crossbar  in   32  write data
//   cmd_from_crossbar    in   1   1 = write, 0 = read
//   ack_to_crossbar      out  1   one-cycle completion pulse
//   rdata_to_crossbar    out  32  read data, valid only with ack; 0 otherwise
//   err_to_crossbar      out  1   high with ack when the transaction timed out
//   busy_to_crossbar     out  1   high whenever state != IDLE
//   req_to_slave         out  1   request to slave, held until ack_from_slave or timeout
//   addr_to_slave        out  32  local address, registered
//   wdata_to_slave       out  32  write data, registered
//   cmd_to_slave         out  1   command, registered
//   ack_from_slave       in   1   slave completion, sampled only in REQ
//   rdata_from_slave     in   32  slave read data, sampled with ack_from_slave
//   timeout_count        out  8   number of timed-out transactions, saturates at 255
// BEHAVIOUR
//   - Reset (sync, active high): state = IDLE, every output = 0, timeout counter = 0, timeout_count = 0.
//     Reset mid-transaction aborts it; the slave sees req_to_slave drop on the next cycle; no ack is issued.
//   - States: IDLE, REQ, RESP, RELEASE. Outputs are decoded from registered state only.
//   - IDLE: if req_from_crossbar=1 at edge E0, capture addr-BASE_ADDR, wdata and cmd, clear the
//     timeout counter, and go to REQ.
//   - REQ: req_to_slave=1; address, data and cmd are held stable.
//     * ack_from_slave=1 at an edge: capture rdata (read), or 0 (write); go to RESP; err=0.
//     * Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0):
//       go to RESP with err=1, rdata=ERR_RDATA (read) or 0 (write), and timeout_count++ (saturating).
//     * ack_from_slave on the same edge as timeout expiry: ack wins, no error.
//   - RESP: ack_to_crossbar=1 for exactly one cycle, with rdata/err as captured. Next state is RELEASE if
//     req_from_crossbar=1, else IDLE.
//   - RELEASE: wait for req_from_crossbar=0, then go to IDLE. This prevents re-issuing a held request.
//   - Minimum latency: request sampled at E0, req_to_slave high after E0, slave ack at E1, and
//     ack_to_crossbar high for the cycle after E1. That is 2 cycles from request to ack; back-to-back
//     transactions take at least 4 cycles.
//   - Outside RESP: rdata_to_crossbar=0 and err_to_crossbar=0. Outside REQ: req_to_slave=0 and
//     ack_from_slave is ignored.
//   - Crossbar input changes after capture do not affect the slave side. If req_from_crossbar drops
//     during REQ (protocol violation), the transaction still completes and ack is still pulsed.
//   - Address subtraction wraps modulo 2^32; no range check is done here.
// TESTING
//   1. Read, BASE=32'h1000_0000, addr=32'h1000_0040; slave acks in 1st REQ cycle with 32'hA5A5_0001
//      -> addr_to_slave=32'h40, cmd=0, ack_to_crossbar 1 cycle with rdata=32'hA5A5_0001, err=0.
//   2. Write, wdata=32'h1234_5678, slave acks after 5 cycles -> req_to_slave held 6 cycles with stable
//      data, ack pulse with rdata=0, err=0.
//   3. Read, slave never acks, TIMEOUT=16 -> req_to_slave drops after 16 REQ cycles,
//      ack+err with rdata=32'hDEAD_BEEF, timeout_count=1.
//   4. ack_from_slave on the exact timeout edge -> normal ack, err=0, timeout_count unchanged.
//   5. Crossbar holds req 3 cycles past ack -> exactly one slave transaction and one ack pulse;
//      busy until req drops.
//   6. rst asserted in REQ -> next cycle all outputs 0, state IDLE; the following request completes normally.

Source files
------------

// File: rtl/slave_if.sv
// ---------------------------------------------------------------------------
// slave_if -- slave-side port of the crossbar.
//
// Takes one granted request from the crossbar, replays it to a single slave
// with the address rebased to the slave's local space, and returns a one-cycle
// ack with read data (or an error response when the slave stays silent for
// too long). Only one transaction is ever in flight.
//
// Ports
//   clk, rst                 clock / synchronous active-high reset
//   req_from_crossbar        request, held by the crossbar until it sees ack
//   addr_from_crossbar       global address
//   wdata_from_crossbar      write data
//   cmd_from_crossbar        1 = write, 0 = read
//   ack_to_crossbar          one-cycle completion pulse
//   rdata_to_crossbar        read data, non-zero only alongside ack
//   err_to_crossbar          timeout flag, only alongside ack
//   busy_to_crossbar         high whenever a transaction is being handled
//   req_to_slave             request to the slave, held until ack or timeout
//   addr_to_slave            local address (global - BASE_ADDR, wrapping)
//   wdata_to_slave           registered write data
//   cmd_to_slave             registered command
//   ack_from_slave           slave completion, only looked at while requesting
//   rdata_from_slave         slave read data, taken with ack_from_slave
//   timeout_count            saturating count of timed-out transactions
// ---------------------------------------------------------------------------
module slave_if #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_from_crossbar,
  input  logic [31:0] addr_from_crossbar,
  input  logic [31:0] wdata_from_crossbar,
  input  logic        cmd_from_crossbar,
  output logic        ack_to_crossbar,
  output logic [31:0] rdata_to_crossbar,
  output logic        err_to_crossbar,
  output logic        busy_to_crossbar,
  output logic        req_to_slave,
  output logic [31:0] addr_to_slave,
  output logic [31:0] wdata_to_slave,
  output logic        cmd_to_slave,
  input  logic        ack_from_slave,
  input  logic [31:0] rdata_from_slave,
  output logic [7:0]  timeout_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        cmd_q, err_q;
  logic [31:0] tmo_cnt;
  logic [7:0]  tmo_total;
  logic        tmo_hit;

  // Timeout fires on the edge that would bring the count of silent REQ
  // cycles up to TIMEOUT_CYCLES. A zero limit never fires.
  assign tmo_hit = (TMO != 32'd0) && ((tmo_cnt + 32'd1) == TMO);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and Moore output decode.
  always_comb begin
    state_nxt         = state;
    ack_to_crossbar   = 1'b0;
    rdata_to_crossbar = '0;
    err_to_crossbar   = 1'b0;
    busy_to_crossbar  = (state != IDLE);
    req_to_slave      = 1'b0;
    case (state)
      IDLE: begin
        if (req_from_crossbar) state_nxt = REQ;
      end
      REQ: begin
        req_to_slave = 1'b1;
        // A slave ack on the expiry edge still counts as a normal completion.
        if (ack_from_slave || tmo_hit) state_nxt = RESP;
      end
      RESP: begin
        ack_to_crossbar   = 1'b1;
        rdata_to_crossbar = rdata_q;
        err_to_crossbar   = err_q;
        // A request still held here is the one just served; park in RELEASE
        // so it is not issued to the slave a second time.
        state_nxt = req_from_crossbar ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!req_from_crossbar) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured transaction, response and timeout bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_cnt   <= '0;
      tmo_total <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_from_crossbar) begin
            addr_q  <= addr_from_crossbar - BASE_ADDR;
            wdata_q <= wdata_from_crossbar;
            cmd_q   <= cmd_from_crossbar;
            tmo_cnt <= '0;
          end
        end
        REQ: begin
          if (ack_from_slave) begin
            rdata_q <= cmd_q ? 32'd0 : rdata_from_slave;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= cmd_q ? 32'd0 : ERR_RDATA;
            err_q   <= 1'b1;
            if (tmo_total != 8'hFF) tmo_total <= tmo_total + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign addr_to_slave  = addr_q;
  assign wdata_to_slave = wdata_q;
  assign cmd_to_slave   = cmd_q;
  assign timeout_count  = tmo_total;

endmodule

// File: tb/tb_slave_if.sv
// Bench for slave_if: table of transactions driven through a crossbar/slave
// model, expected responses queued at issue and compared at the ack pulse.
module tb_slave_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_from_crossbar;
  logic [31:0] addr_from_crossbar, wdata_from_crossbar;
  logic        cmd_from_crossbar;
  logic        ack_to_crossbar, err_to_crossbar, busy_to_crossbar;
  logic [31:0] rdata_to_crossbar;
  logic        req_to_slave, cmd_to_slave;
  logic [31:0] addr_to_slave, wdata_to_slave;
  logic        ack_from_slave;
  logic [31:0] rdata_from_slave;
  logic [7:0]  timeout_count;

  slave_if #(
    .BASE_ADDR(32'h1000_0000), .TIMEOUT_CYCLES(16), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .req_from_crossbar(req_from_crossbar),
    .addr_from_crossbar(addr_from_crossbar),
    .wdata_from_crossbar(wdata_from_crossbar),
    .cmd_from_crossbar(cmd_from_crossbar),
    .ack_to_crossbar(ack_to_crossbar),
    .rdata_to_crossbar(rdata_to_crossbar),
    .err_to_crossbar(err_to_crossbar),
    .busy_to_crossbar(busy_to_crossbar),
    .req_to_slave(req_to_slave),
    .addr_to_slave(addr_to_slave),
    .wdata_to_slave(wdata_to_slave),
    .cmd_to_slave(cmd_to_slave),
    .ack_from_slave(ack_from_slave),
    .rdata_from_slave(rdata_from_slave),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // ack_at: REQ cycle in which the slave acks (0 = never); hold: cycles the
  // crossbar keeps req up after the ack; drop: crossbar drops req during REQ.
  typedef struct {
    logic        cmd;
    logic [31:0] addr, wdata, srdata;
    int          ack_at, hold;
    bit          drop;
    logic [31:0] exp_addr, exp_rdata;
    logic        exp_err;
    int          exp_reqcyc;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          reqcyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_tc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ack"},   32'(ack_to_crossbar),  32'd0);
    chk({tag, " rdata"}, rdata_to_crossbar,     32'd0);
    chk({tag, " err"},   32'(err_to_crossbar),  32'd0);
    chk({tag, " busy"},  32'(busy_to_crossbar), 32'd0);
    chk({tag, " sreq"},  32'(req_to_slave),     32'd0);
    chk({tag, " saddr"}, addr_to_slave,         32'd0);
    chk({tag, " swdat"}, wdata_to_slave,        32'd0);
    chk({tag, " scmd"},  32'(cmd_to_slave),     32'd0);
    chk({tag, " tcnt"},  32'(timeout_count),    32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   k;
    bit   done;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.reqcyc = v.exp_reqcyc;
    sb.push_back(e);
    req_from_crossbar   = 1'b1;
    addr_from_crossbar  = v.addr;
    wdata_from_crossbar = v.wdata;
    cmd_from_crossbar   = v.cmd;
    k = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      // scramble crossbar side after capture; the slave side must not care
      addr_from_crossbar  = $urandom;
      wdata_from_crossbar = $urandom;
      cmd_from_crossbar   = ~v.cmd;
      if (ack_to_crossbar) begin
        done = 1;
        e = sb.pop_front();
        if (e.err && exp_tc < 255) exp_tc++;
        chk("resp rdata", rdata_to_crossbar, e.rdata);
        chk("resp err", 32'(err_to_crossbar), 32'(e.err));
        chk("req cycles", 32'(k), 32'(e.reqcyc));
        chk("resp sreq", 32'(req_to_slave), 32'd0);
        chk("resp busy", 32'(busy_to_crossbar), 32'd1);
        chk("timeout_count", 32'(timeout_count), 32'(exp_tc));
        if (v.hold == 0) req_from_crossbar = 1'b0;
      end else if (req_to_slave) begin
        k++;
        chk("slave addr", addr_to_slave, v.exp_addr);
        chk("slave wdata", wdata_to_slave, v.wdata);
        chk("slave cmd", 32'(cmd_to_slave), 32'(v.cmd));
        chk("req rdata", rdata_to_crossbar, 32'd0);
        chk("req err", 32'(err_to_crossbar), 32'd0);
        if (v.drop && k == 1) req_from_crossbar = 1'b0;
        if (k == v.ack_at) begin
          ack_from_slave = 1'b1; rdata_from_slave = v.srdata;
        end else begin
          ack_from_slave = 1'b0; rdata_from_slave = $urandom;
        end
      end else begin
        chk("unexpected idle", 32'(busy_to_crossbar), 32'd1);
        done = 1;
        void'(sb.pop_front());
      end
    end
    ack_from_slave = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL ack wait: no ack within 40 cycles");
      void'(sb.pop_front());
    end
    for (int h = 0; h < v.hold; h++) begin
      ack_from_slave = 1'b1;  // must be ignored outside REQ
      @(posedge clk); #1;
      chk("hold busy", 32'(busy_to_crossbar), 32'd1);
      chk("hold ack", 32'(ack_to_crossbar), 32'd0);
      chk("hold sreq", 32'(req_to_slave), 32'd0);
    end
    ack_from_slave    = 1'b0;
    req_from_crossbar = 1'b0;
    @(posedge clk); #1;
    chk("end busy", 32'(busy_to_crossbar), 32'd0);
    chk("end ack", 32'(ack_to_crossbar), 32'd0);
  endtask

  vec_t vecs[7];
  vec_t tmo_v;

  initial begin
    //                 cmd  addr           wdata          srdata      ack hold drop exp_addr       exp_rdata      err cyc
    vecs[0] = '{1'b0, 32'h1000_0040, 32'h0000_0000, 32'hA5A5_0001,  1, 0, 0, 32'h0000_0040, 32'hA5A5_0001, 1'b0,  1};
    vecs[1] = '{1'b1, 32'h1000_0100, 32'h1234_5678, 32'hFFFF_FFFF,  6, 0, 0, 32'h0000_0100, 32'h0000_0000, 1'b0,  6};
    vecs[2] = '{1'b0, 32'h1000_0008, 32'h0000_0000, 32'h0000_0000,  0, 0, 0, 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 16};
    vecs[3] = '{1'b0, 32'h1000_000C, 32'h0000_0000, 32'h0BAD_F00D, 16, 0, 0, 32'h0000_000C, 32'h0BAD_F00D, 1'b0, 16};
    vecs[4] = '{1'b0, 32'h1000_0020, 32'h0000_0000, 32'h1111_2222,  2, 3, 0, 32'h0000_0020, 32'h1111_2222, 1'b0,  2};
    vecs[5] = '{1'b1, 32'h0000_0010, 32'hCAFE_0001, 32'h0000_0000,  0, 0, 0, 32'hF000_0010, 32'h0000_0000, 1'b1, 16};
    vecs[6] = '{1'b0, 32'h2000_0004, 32'h0000_0000, 32'h7777_8888,  3, 0, 1, 32'h1000_0004, 32'h7777_8888, 1'b0,  3};

    rst = 1'b1;
    req_from_crossbar = 1'b0; addr_from_crossbar = '0; wdata_from_crossbar = '0;
    cmd_from_crossbar = 1'b0; ack_from_slave = 1'b0; rdata_from_slave = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset while the slave is being requested
    req_from_crossbar = 1'b1; addr_from_crossbar = 32'h1000_0044; cmd_from_crossbar = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset sreq", 32'(req_to_slave), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("midreset");
    exp_tc = 0;
    rst = 1'b0; req_from_crossbar = 1'b0;
    @(posedge clk); #1;
    chk("post-reset ack", 32'(ack_to_crossbar), 32'd0);
    chk("post-reset busy", 32'(busy_to_crossbar), 32'd0);
    run_vec(vecs[0]);

    // drive timeout_count into saturation and one past it
    tmo_v = vecs[2];
    while (exp_tc < 255) run_vec(tmo_v);
    run_vec(tmo_v);
    chk("tcnt saturated", 32'(timeout_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
